// File: rtl/cdb_result_queue_pkg.sv
// cdb_result_queue_pkg: CDB result record and default queue depth shared by the result queues.
package cdb_result_queue_pkg;
    localparam int CDB_Q_DEPTH = 4;
    typedef struct packed {
        logic        valid;
        logic [4:0]  rob_id;
        logic [5:0]  pd;
        logic [4:0]  rd;
        logic [31:0] rd_v;
    } cdb_t;
endpackage

// File: rtl/cdb_result_queue.sv
// cdb_result_queue: per-unit FIFO of completed results feeding one CDB arbiter input.
// Optional macro CDB_QUEUE_BYPASS_EN: an empty queue forwards in_result to out_cdb in the same cycle.
module cdb_result_queue
    import cdb_result_queue_pkg::*;
#(
    parameter int DEPTH = CDB_Q_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           in_valid,
    input  cdb_t           in_result,
    output logic           in_ready,
    input  logic           ack,
    output cdb_t           out_cdb,
    output logic [PTR_W:0] count
);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    cdb_t            mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   occ;
    cdb_t            wdata, head;
    logic            empty, byp, push, pop;

    always_comb begin
        wdata = in_result;
        wdata.valid = 1'b1;
        head = mem[rd_ptr];
        head.valid = 1'b1;
    end

    assign empty    = occ == '0;
    assign in_ready = occ != FULL;
`ifdef CDB_QUEUE_BYPASS_EN
    assign byp = empty & in_valid & ~flush;
`else
    assign byp = 1'b0;
`endif
    // A bypassed result that is acked this cycle is consumed and never stored
    assign push    = in_valid & in_ready & ~flush & ~(byp & ack);
    assign pop     = ack & ~empty & ~flush;
    assign out_cdb = !empty ? head : (byp ? wdata : '0);
    assign count   = occ;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            occ <= occ + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: tb/tb_cdb_result_queue.sv
// tb_cdb_result_queue: directed plus randomized checks of cdb_result_queue against a queue model.
module tb_cdb_result_queue;
    import cdb_result_queue_pkg::*;
    localparam int D = CDB_Q_DEPTH;

    logic       clk = 1'b0;
    logic       rst = 1'b0, flush = 1'b0, in_valid = 1'b0, ack = 1'b0;
    logic       in_ready;
    cdb_t       in_result = '0, out_cdb;
    logic [2:0] count;
    int         tests = 0, fails = 0;
    bit         live = 0;
    cdb_t       q[$];

    always #5 clk = ~clk;

    cdb_result_queue dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_result(in_result),
        .in_ready(in_ready), .ack(ack), .out_cdb(out_cdb), .count(count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic cdb_t mk(input int id);
        cdb_t c;
        c.valid  = 1'($urandom);
        c.rob_id = 5'(id);
        c.pd     = 6'($urandom);
        c.rd     = 5'($urandom);
        c.rd_v   = $urandom;
        return c;
    endfunction

    // One cycle: drive, check against the model, clock, update the model
    task automatic step(input logic r, input logic f, input logic v, input cdb_t res, input logic a);
        cdb_t e, w;
        bit   byp, pu, po;
        rst = r; flush = f; in_valid = v; in_result = res; ack = a;
        #1;
        w = res;
        w.valid = 1'b1;
        byp = 0;
`ifdef CDB_QUEUE_BYPASS_EN
        byp = q.size() == 0 && v && !f;
`endif
        e = q.size() > 0 ? q[0] : (byp ? w : '0);
        if (live) begin
            chk("out_cdb", 64'(out_cdb), 64'(e));
            chk("in_ready", 64'(in_ready), 64'(q.size() < D));
            chk("count", 64'(count), 64'(q.size()));
        end
        pu = v && q.size() < D && !f && !(byp && a);
        po = a && q.size() > 0 && !f;
        @(posedge clk);
        if (r || f) q.delete();
        else begin
            if (po) void'(q.pop_front());
            if (pu) q.push_back(w);
        end
        if (r) live = 1;
        #1;
        rst = 0; flush = 0; in_valid = 0; ack = 0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0);
    endtask

    task automatic push_ids(input int first, input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1, mk(first + i), 0);
    endtask

    // Pop the head on the arbiter's one-in-three schedule, checking its rob_id
    task automatic drain_expect(input int id);
        idle(2);
        chk("drain_rob_id", 64'(out_cdb.rob_id), 64'(id));
        chk("drain_valid", 64'(out_cdb.valid), 64'd1);
        step(0, 0, 0, '0, 1);
    endtask

    initial begin
        @(negedge clk);
        step(1, 0, 0, '0, 0);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_ready", 64'(in_ready), 64'd1);
        chk("reset_valid", 64'(out_cdb.valid), 64'd0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, '0, logic'(i % 3 == 0));
        chk("idle_count", 64'(count), 64'd0);

        push_ids(1, 3);
        chk("fifo_count3", 64'(count), 64'd3);
        for (int k = 1; k <= 3; k++) drain_expect(k);
        chk("fifo_empty", 64'(count), 64'd0);

        push_ids(1, 4);
        chk("full_count", 64'(count), 64'd4);
        chk("full_ready", 64'(in_ready), 64'd0);
        step(0, 0, 1, mk(5), 1);
        chk("after_pop_count", 64'(count), 64'd3);
        chk("after_pop_ready", 64'(in_ready), 64'd1);
        step(0, 0, 1, mk(5), 0);
        chk("wrap_count", 64'(count), 64'd4);
        for (int k = 2; k <= 5; k++) drain_expect(k);

        push_ids(8, 2);
        step(0, 0, 1, mk(10), 1);
        chk("pushpop_count", 64'(count), 64'd2);
        for (int k = 9; k <= 10; k++) drain_expect(k);

        push_ids(11, 3);
        step(0, 1, 1, mk(14), 1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(out_cdb.valid), 64'd0);
        idle(2);

        step(0, 0, 1, mk(7), 1);
`ifdef CDB_QUEUE_BYPASS_EN
        chk("bypass_count", 64'(count), 64'd0);
`else
        chk("nobypass_count", 64'(count), 64'd1);
        chk("nobypass_rob_id", 64'(out_cdb.rob_id), 64'd7);
        drain_expect(7);
`endif

        for (int i = 0; i < 600; i++)
            step(logic'($urandom_range(0, 96) == 0), logic'($urandom_range(0, 22) == 0),
                 logic'($urandom_range(0, 1)), mk(int'($urandom_range(0, 31))), logic'(i % 3 == 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cdb_result_queue.md
Name: cdb_result_queue

Overview:
- Producer-side buffer feeding one input of the CDB round-robin arbiter.
- Each functional unit (ALU, MUL, MEM) holds its completed results in one instance.
- Each instance presents the oldest result as a cdb_t and retires it on the arbiter's per-unit ack.
- Decouples execution completion from the arbiter's fixed one-slot-in-three grant schedule, and flushes on branch mispredict.

Parameters:
- DEPTH, 4, number of result entries; power of two, >= 2.
- PTR_W, $clog2(DEPTH), read/write pointer width (derived; not overridden).

Ports:
- clk  input  1  clock.
- rst  input  1  reset: synchronous, active-high.
- flush  input  1  branch-mispredict squash (same signal that drives the arbiter's branch input).
- in_valid  input  1  execution unit has a completed result.
- in_result  input  cdb_t  completed result (valid, rob_id, pd, rd, rd_v).
- in_ready  output  1  queue can accept in_result this cycle.
- ack  input  1  arbiter grant: out_cdb is sampled onto the CDB this cycle.
- out_cdb  output  cdb_t  head result to the arbiter.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH-entry circular buffer with rd_ptr, wr_ptr (PTR_W bits, wrap modulo DEPTH) and a count register.
- Reset: rd_ptr = wr_ptr = 0, count = 0. Consequently in_ready = 1 and out_cdb = '0 (valid = 0) in the first cycle after reset. Reset mid-operation discards all entries.
- Outputs:
  - out_cdb = entry[rd_ptr] with valid forced to 1 when count > 0; otherwise '0. Driven from registers; no combinational path from ack.
  - in_ready = (count != DEPTH); combinational from count only, never from ack.
- push = in_valid & in_ready & ~flush. Writes in_result at wr_ptr and stores valid as 1 regardless of in_result.valid.
- pop = ack & (count != 0) & ~flush. Advances rd_ptr. The arbiter asserts ack every third cycle whether or not out_cdb.valid is set; ack with count = 0 is a no-op.
- Push and pop in the same cycle: both pointers advance and count is unchanged.
- Latency: a result pushed in cycle N is visible on out_cdb in cycle N+1 at the earliest. Strict FIFO order.
- Full: in_ready = 0. Upstream holds in_valid/in_result stable. A pop while full does not let a push into the same cycle; in_ready rises the cycle after the pop.
- Flush (priority over push/pop):
  - Next cycle: rd_ptr = wr_ptr = 0, count = 0.
  - A result presented in the flush cycle is dropped.
  - out_cdb in the flush cycle still shows the head; the arbiter zeroes the CDB during branch and the two cycles after it.
- Results pushed in the two cycles after flush are retained. The arbiter may squash them if granted in its blanking window, so upstream must not issue post-flush results that could complete within 2 cycles of flush. The queue does not enforce this.
- count never exceeds DEPTH. Pointer wrap is 3 -> 0 for DEPTH = 4.

Optional Feature:
- Macro CDB_QUEUE_BYPASS_EN.
- Defined: when count == 0 and in_valid & ~flush, out_cdb = in_result with valid = 1 in the same cycle.
  - If ack is also high, the result is consumed directly and not written; count stays 0.
  - If ack is low, it is enqueued normally.
  - Adds a combinational in_result -> out_cdb path.
- Undefined: minimum in-to-out latency is 1 cycle, as above.

Decomposition:
- cdb_t already lives in rv32i_types.
- Add localparam CDB_Q_DEPTH = 4 to rv32i_types for top-level instantiation.
- No sub-module: pointers, counter and storage array stay inline (well under 200 lines).

Test Plan (DEPTH = 4):
- Reset, then idle 5 cycles -> count = 0, in_ready = 1, out_cdb.valid = 0 every cycle; ack pulses cause no change.
- Push rob_id 1, 2, 3 back-to-back with ack = 0; then ack every 3rd cycle -> out_cdb.rob_id = 1, 2, 3 in order; count 3 -> 2 -> 1 -> 0, decrementing the cycle after each ack.
- Push 4 results -> count = 4, in_ready = 0. Hold 5th (rob_id 5) valid; ack pops rob_id 1 -> next cycle in_ready = 1 and rob_id 5 is accepted at wr_ptr 0 (wrap). Drain order is 2, 3, 4, 5.
- count = 2, in_valid = 1 and ack = 1 in the same cycle -> count stays 2; new entry appears after the existing two.
- count = 3, flush = 1 with in_valid = 1 and ack = 1 -> next cycle count = 0, out_cdb.valid = 0; flush-cycle input never appears on out_cdb.
- CDB_QUEUE_BYPASS_EN defined, empty, in_valid & ack with rob_id 7 -> out_cdb.rob_id = 7, valid = 1 that same cycle; count remains 0. Undefined: rob_id 7 appears on out_cdb the next cycle and count = 1.
